ysyx_23060061_multi_delay_gen: RTL and testbench

Parametrised, multi-channel latency injector for the NPC simulation memory path. Each channel accepts a start request, waits a per-request delay, then emits a one-cycle trigger; the delay is zero, fixed, or pseudo-random from a shared LFSR. Bus-side models (IFU/LSU SRAM, AXI-lite slaves) use one channel each to stall `ready`/`valid` realistically.

---
 rtl/ysyx_23060061_multi_delay_gen.sv | 114 +++++++++++
 tb/tb_ysyx_23060061_multi_delay_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060061_multi_delay_gen.sv
// Multi-channel latency injector: each channel turns a start request into a one-cycle
// trigger after a zero, fixed or LFSR-derived pseudo-random delay.
module ysyx_23060061_multi_delay_gen #(
    parameter int                NCH    = 2,
    parameter int                CNT_W  = 8,
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_fixed,
    input  logic [CNT_W-1:0]  cfg_min,
    input  logic [CNT_W-1:0]  cfg_mask,
    input  logic [NCH-1:0]    req,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    trigger,
    output logic [LFSR_W-1:0] lfsr_o
);

    // Galois right-shift tap masks for maximal-length sequences; unlisted widths reuse the 16-bit mask.
    localparam logic [31:0] TAP_TABLE =
        (LFSR_W == 8)  ? 32'h0000_00B8 :
        (LFSR_W == 10) ? 32'h0000_0240 :
        (LFSR_W == 12) ? 32'h0000_0829 :
        (LFSR_W == 16) ? 32'h0000_B400 :
        (LFSR_W == 20) ? 32'h0009_0000 :
        (LFSR_W == 24) ? 32'h00E1_0000 :
        (LFSR_W == 32) ? 32'h8020_0003 : 32'h0000_B400;
    localparam logic [LFSR_W-1:0] TAPS     = TAP_TABLE[LFSR_W-1:0];
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        FIRE
    } state_t;

    logic [LFSR_W-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= SEED_EFF;
        end else if (lfsr[0]) begin
            lfsr <= (lfsr >> 1) ^ TAPS;
        end else begin
            lfsr <= lfsr >> 1;
        end
    end

    assign lfsr_o = lfsr;

    for (genvar i = 0; i < NCH; i++) begin : gen_ch
        // Each channel reads the LFSR rotated by a different amount so simultaneous starts diverge.
        localparam int ROT = (3 * i) % LFSR_W;

        state_t           state, state_n;
        logic [CNT_W-1:0] cnt, cnt_n;
        logic [CNT_W-1:0] slice;
        logic [CNT_W:0]   sum;
        logic [CNT_W-1:0] rand_d;
        logic [CNT_W-1:0] delay;

        always_comb begin
            slice = '0;
            for (int b = 0; b < CNT_W; b++) begin
                slice[b] = lfsr[(b + ROT) % LFSR_W];
            end
            sum    = {1'b0, cfg_min} + {1'b0, slice & cfg_mask};
            rand_d = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
            case (cfg_mode)
                2'b01:   delay = cfg_fixed;
                2'b10:   delay = rand_d;
                default: delay = '0;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                state <= state_n;
                cnt   <= cnt_n;
            end
        end

        // The delay is captured only on acceptance, so later config changes leave running channels alone.
        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            case (state)
                IDLE: begin
                    if (req[i]) begin
                        cnt_n   = delay;
                        state_n = (delay == '0) ? FIRE : COUNT;
                    end
                end
                COUNT: begin
                    cnt_n = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_n = FIRE;
                    end
                end
                FIRE:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end

        assign busy[i]    = (state != IDLE);
        assign trigger[i] = (state == FIRE);
    end

endmodule

// File: tb/tb_ysyx_23060061_multi_delay_gen.sv
// Self-checking bench: a cycle-level model pushes expected trigger cycles into per-channel
// queues on acceptance; each scenario task pops and compares them as the DUT runs.
module tb_ysyx_23060061_multi_delay_gen;

    localparam int          NCH    = 2;
    localparam int          CNT_W  = 8;
    localparam int          LFSR_W = 16;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_fixed, cfg_min, cfg_mask;
    logic [1:0]  req;
    logic [1:0]  busy, trigger;
    logic [15:0] lfsr_o;

    always #5 clk = ~clk;

    ysyx_23060061_multi_delay_gen #(
        .NCH(NCH), .CNT_W(CNT_W), .LFSR_W(LFSR_W), .SEED(SEED)
    ) dut (
        .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_fixed(cfg_fixed),
        .cfg_min(cfg_min), .cfg_mask(cfg_mask), .req(req),
        .busy(busy), .trigger(trigger), .lfsr_o(lfsr_o)
    );

    int          cyc;
    logic [15:0] m_lfsr;
    int          q0[$];
    int          q1[$];
    int          acc_c[NCH];
    int          trig_c[NCH];
    int          last_d[NCH];
    logic [1:0]  exp_trig, exp_busy;
    int          n_checks, n_fail;

    function automatic logic [15:0] lfsr_next(logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int model_d(int c);
        logic [15:0] r;
        logic [8:0]  s;
        r = m_lfsr;
        for (int k = 0; k < 3 * c; k++) r = {r[0], r[15:1]};
        case (cfg_mode)
            2'b01: return int'(cfg_fixed);
            2'b10: begin
                s = {1'b0, cfg_min} + {1'b0, r[7:0] & cfg_mask};
                return (s > 9'd255) ? 255 : int'(s);
            end
            default: return 0;
        endcase
    endfunction

    // Advance one clock: model acceptance on the edge, then derive the expected outputs.
    task automatic tick();
        int d;
        if (rst) begin
            q0.delete();
            q1.delete();
            for (int c = 0; c < NCH; c++) begin
                acc_c[c]  = -1;
                trig_c[c] = -1;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (req[c] && cyc > trig_c[c]) begin
                    d         = model_d(c);
                    last_d[c] = d;
                    acc_c[c]  = cyc + 1;
                    trig_c[c] = cyc + d + 1;
                    if (c == 0) q0.push_back(trig_c[c]);
                    else        q1.push_back(trig_c[c]);
                end
            end
        end
        m_lfsr = rst ? SEED : lfsr_next(m_lfsr);
        @(posedge clk);
        #1;
        cyc++;
        exp_trig = '0;
        if (q0.size() > 0 && q0[0] == cyc) begin exp_trig[0] = 1'b1; void'(q0.pop_front()); end
        if (q1.size() > 0 && q1[0] == cyc) begin exp_trig[1] = 1'b1; void'(q1.pop_front()); end
        for (int c = 0; c < NCH; c++) exp_busy[c] = (acc_c[c] <= cyc) && (cyc <= trig_c[c]);
    endtask

    task automatic test_reset();
        logic [15:0] seq[3];
        seq = '{16'hACE1, 16'hE270, 16'h7138};
        rst = 1'b1; req = '0; cfg_mode = 2'b00;
        cfg_fixed = 8'd0; cfg_min = 8'd0; cfg_mask = 8'd0;
        repeat (3) tick();
        n_checks++;
        if (busy !== 2'b00 || trigger !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs busy=%b trigger=%b required 00/00", busy, trigger);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (lfsr_o !== seq[i] || busy !== 2'b00 || trigger !== 2'b00) begin
                n_fail++;
                $display("[TB] FAIL reset_lfsr step %0d lfsr=%h required %h busy=%b trigger=%b",
                         i, lfsr_o, seq[i], busy, trigger);
            end
            if (i < 2) tick();
        end
    endtask

    task automatic test_fixed();
        int t, seen, tr[$];
        cfg_mode = 2'b01; cfg_fixed = 8'd30;
        tick();
        t = cyc; seen = -1; req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (trigger[0] && seen < 0) seen = cyc;
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy || lfsr_o !== m_lfsr) begin
                n_fail++;
                $display("[TB] FAIL fixed_sb cyc=%0d trigger=%b/%b busy=%b/%b lfsr=%h/%h",
                         cyc, trigger, exp_trig, busy, exp_busy, lfsr_o, m_lfsr);
            end
            tick();
        end
        n_checks++;
        if (seen != t + 31) begin
            n_fail++;
            $display("[TB] FAIL fixed_latency trigger cycle=%0d required %0d", seen, t + 31);
        end
        req[0] = 1'b1;
        for (int k = 0; k < 110; k++) begin
            tick();
            if (trigger[0]) tr.push_back(cyc);
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL fixed_held_sb cyc=%0d trigger=%b/%b busy=%b/%b",
                         cyc, trigger, exp_trig, busy, exp_busy);
            end
        end
        req[0] = 1'b0;
        n_checks++;
        if (tr.size() < 3 || tr[1] - tr[0] != 32 || tr[2] - tr[1] != 32) begin
            n_fail++;
            $display("[TB] FAIL fixed_period triggers=%0d periods=%0d,%0d required 32",
                     tr.size(), (tr.size() > 1) ? tr[1] - tr[0] : -1,
                     (tr.size() > 2) ? tr[2] - tr[1] : -1);
        end
        repeat (40) tick();
    endtask

    task automatic test_bypass();
        int t, ntrig;
        cfg_mode = 2'b00;
        t = cyc; ntrig = 0; req[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            n_checks++;
            if (trigger[1] !== ((k % 2) == 1) || trigger !== exp_trig || busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL bypass_held cyc=%0d trigger=%b/%b busy=%b/%b",
                         cyc, trigger, exp_trig, busy, exp_busy);
            end
        end
        req[1] = 1'b0;
        tick();
        cfg_mode = 2'b01; cfg_fixed = 8'd5;
        for (int k = 0; k < 15; k++) begin
            req[1] = (k == 0 || k == 2 || k == 4 || k == 6);
            tick();
            if (trigger[1]) ntrig++;
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL busy_pulses_sb cyc=%0d trigger=%b/%b busy=%b/%b",
                         cyc, trigger, exp_trig, busy, exp_busy);
            end
        end
        req[1] = 1'b0;
        n_checks++;
        if (ntrig != 1) begin
            n_fail++;
            $display("[TB] FAIL busy_pulses trigger count=%0d required 1", ntrig);
        end
        repeat (5) tick();
    endtask

    task automatic test_random();
        int ntrig, prev, bad, t, seen, waited;
        cfg_mode = 2'b10; cfg_min = 8'd4; cfg_mask = 8'h03;
        ntrig = 0; prev = -1; bad = 0;
        req[0] = 1'b1;
        for (int k = 0; k < 2000 && ntrig < 200; k++) begin
            tick();
            if (trigger[0]) begin
                if (prev >= 0 && (cyc - prev < 6 || cyc - prev > 9)) bad++;
                prev = cyc;
                ntrig++;
            end
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL random_sb cyc=%0d trigger=%b/%b busy=%b/%b d=%0d",
                         cyc, trigger, exp_trig, busy, exp_busy, last_d[0]);
            end
        end
        req[0] = 1'b0;
        n_checks++;
        if (ntrig < 200 || bad != 0) begin
            n_fail++;
            $display("[TB] FAIL random_range triggers=%0d required 200, out-of-range periods=%0d required 0",
                     ntrig, bad);
        end
        repeat (12) tick();
        cfg_min = 8'd250; cfg_mask = 8'h0F;
        waited = 0;
        while (m_lfsr[3:0] != 4'hF && waited < 200) begin
            tick();
            waited++;
        end
        t = cyc; seen = -1; req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        for (int k = 0; k < 270; k++) begin
            if (trigger[0] && seen < 0) seen = cyc;
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL saturate_sb cyc=%0d trigger=%b/%b busy=%b/%b",
                         cyc, trigger, exp_trig, busy, exp_busy);
            end
            tick();
        end
        n_checks++;
        if (seen != t + 256) begin
            n_fail++;
            $display("[TB] FAIL saturate_latency trigger cycle=%0d required %0d", seen, t + 256);
        end
    endtask

    task automatic test_independence();
        int t, d0, d1, seen0, seen1;
        cfg_mode = 2'b10; cfg_min = 8'd0; cfg_mask = 8'hFF;
        tick();
        t = cyc; d0 = model_d(0); d1 = model_d(1); seen0 = -1; seen1 = -1;
        req = 2'b11;
        tick();
        req = 2'b00;
        for (int k = 0; k < 270; k++) begin
            if (trigger[0] && seen0 < 0) seen0 = cyc;
            if (trigger[1] && seen1 < 0) seen1 = cyc;
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL indep_sb cyc=%0d trigger=%b/%b busy=%b/%b",
                         cyc, trigger, exp_trig, busy, exp_busy);
            end
            tick();
        end
        n_checks++;
        if (seen0 != t + d0 + 1 || seen1 != t + d1 + 1) begin
            n_fail++;
            $display("[TB] FAIL indep_latency ch0=%0d required %0d ch1=%0d required %0d",
                     seen0, t + d0 + 1, seen1, t + d1 + 1);
        end
        cfg_mode = 2'b01; cfg_fixed = 8'd30;
        t = cyc; seen0 = -1; req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 5) cfg_fixed = 8'd2;
            if (trigger[0] && seen0 < 0) seen0 = cyc;
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy) begin
                n_fail++;
                $display("[TB] FAIL freeze_sb cyc=%0d trigger=%b/%b busy=%b/%b",
                         cyc, trigger, exp_trig, busy, exp_busy);
            end
            tick();
        end
        n_checks++;
        if (seen0 != t + 31) begin
            n_fail++;
            $display("[TB] FAIL freeze_latency trigger cycle=%0d required %0d", seen0, t + 31);
        end
    endtask

    task automatic test_reset_mid();
        int t, ntrig;
        cfg_mode = 2'b01; cfg_fixed = 8'd30;
        t = cyc; ntrig = 0; req[0] = 1'b1;
        tick();
        req[0] = 1'b0;
        while (cyc < t + 10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (busy !== 2'b00 || trigger !== 2'b00 || lfsr_o !== 16'hACE1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid busy=%b trigger=%b lfsr=%h required 00/00/ace1",
                     busy, trigger, lfsr_o);
        end
        for (int k = 0; k < 40; k++) begin
            tick();
            if (trigger[0]) ntrig++;
            n_checks++;
            if (trigger !== exp_trig || busy !== exp_busy || lfsr_o !== m_lfsr) begin
                n_fail++;
                $display("[TB] FAIL reset_mid_sb cyc=%0d trigger=%b/%b busy=%b/%b lfsr=%h/%h",
                         cyc, trigger, exp_trig, busy, exp_busy, lfsr_o, m_lfsr);
            end
        end
        n_checks++;
        if (ntrig != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_abort trigger count=%0d required 0", ntrig);
        end
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0; m_lfsr = SEED;
        exp_trig = '0; exp_busy = '0;
        for (int c = 0; c < NCH; c++) begin
            acc_c[c] = -1; trig_c[c] = -1; last_d[c] = 0;
        end
        rst = 1'b1; req = '0;
        test_reset();
        test_fixed();
        test_bypass();
        test_random();
        test_independence();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
